// File: rtl/char_scroller.sv
// Scrolling character display engine: loads a short message in IDLE, then walks
// every glyph column of every character through an external ROM in RUN.
module char_scroller #(
  parameter int MSG_LEN = 8,
  parameter int COL_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic [5:0] rom_face,
  output logic [2:0] rom_index,
  input  logic [7:0] rom_col,
  output logic [7:0] col_out,
  output logic       col_strobe,
  output logic       col_first,
  output logic       busy
);

  localparam int PW = $clog2(MSG_LEN);
  localparam int CW = PW + 1;
  localparam int DW = (COL_DIV > 1) ? $clog2(COL_DIV) : 1;
  localparam logic [CW-1:0] FULL   = CW'(MSG_LEN);
  localparam logic [DW-1:0] D_LAST = DW'(COL_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [5:0]    msg_buf [MSG_LEN];
  logic [CW-1:0] count;
  logic [PW-1:0] p;
  logic [PW-1:0] p_next;
  logic [DW-1:0] d;
  logic          wr;
  logic          start_ok;
  logic          capture;
  logic [5:0]    entry_face;

  assign char_ready = (state == IDLE) && (count < FULL) && !reset;
  assign wr         = char_valid && char_ready && !clr;
  // A write landing in the start cycle counts towards a non-empty message.
  assign start_ok   = (state == IDLE) && start && !clr && ((count != '0) || wr);
  assign capture    = (state == RUN) && !stop && (d == D_LAST);
  assign entry_face = (count == '0) ? char_in : msg_buf[0];

  always_comb begin
    p_next = p;
    if (rom_index == 3'd7) begin
      if ({1'b0, p} == (count - CW'(1)))
        p_next = '0;
      else
        p_next = p + PW'(1);
    end
  end

  // Buffer has no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (wr)
      msg_buf[count[PW-1:0]] <= char_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      p          <= '0;
      d          <= '0;
      rom_face   <= '0;
      rom_index  <= '0;
      col_out    <= '0;
      col_strobe <= 1'b0;
      col_first  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          col_strobe <= 1'b0;
          col_first  <= 1'b0;
          if (clr)
            count <= '0;
          else if (wr)
            count <= count + CW'(1);
          if (start_ok) begin
            state     <= RUN;
            busy      <= 1'b1;
            p         <= '0;
            d         <= '0;
            rom_face  <= entry_face;
            rom_index <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            p          <= '0;
            d          <= '0;
            rom_face   <= '0;
            rom_index  <= '0;
            col_strobe <= 1'b0;
            col_first  <= 1'b0;
          end else begin
            d          <= (d == D_LAST) ? '0 : d + DW'(1);
            col_strobe <= capture;
            // ROM address advances on the same edge that captures its column.
            if (capture) begin
              col_out   <= rom_col;
              col_first <= (p == '0) && (rom_index == 3'd0);
              rom_index <= rom_index + 3'd1;
              p         <= p_next;
              rom_face  <= msg_buf[p_next];
            end else begin
              col_first <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_scroller.sv
// Bench for char_scroller: two instances (COL_DIV 4 and 1) share one stimulus
// stream and are compared every cycle against a timeline-based reference model.
module tb_char_scroller;

  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic [5:0] char_in;
  logic       start;
  logic       stop;
  logic       clr;

  logic       dut_ready  [2];
  logic [5:0] dut_face   [2];
  logic [2:0] dut_index  [2];
  logic [7:0] dut_romcol [2];
  logic [7:0] dut_col    [2];
  logic       dut_strobe [2];
  logic       dut_first  [2];
  logic       dut_busy   [2];

  int vectors = 0;
  int miscompares = 0;

  int         cnt     [2];
  logic [5:0] mem     [2][ML];
  bit         running [2];
  int         cyc     [2];
  logic [7:0] col_m   [2];
  bit         strobe_m[2];
  bit         first_m [2];

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(logic [5:0] f, logic [2:0] x);
    return {f[4:0], x} ^ {8{f[5]}};
  endfunction

  function automatic int divOf(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  assign dut_romcol[0] = glyph(dut_face[0], dut_index[0]);
  assign dut_romcol[1] = glyph(dut_face[1], dut_index[1]);

  char_scroller #(.MSG_LEN(ML), .COL_DIV(4)) dut0 (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(dut_ready[0]), .start(start), .stop(stop), .clr(clr),
    .rom_face(dut_face[0]), .rom_index(dut_index[0]), .rom_col(dut_romcol[0]),
    .col_out(dut_col[0]), .col_strobe(dut_strobe[0]), .col_first(dut_first[0]),
    .busy(dut_busy[0])
  );

  char_scroller #(.MSG_LEN(ML), .COL_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(dut_ready[1]), .start(start), .stop(stop), .clr(clr),
    .rom_face(dut_face[1]), .rom_index(dut_index[1]), .rom_col(dut_romcol[1]),
    .col_out(dut_col[1]), .col_strobe(dut_strobe[1]), .col_first(dut_first[1]),
    .busy(dut_busy[1])
  );

  task automatic checkOutput(string tag, int k, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s[%0d] at %0t: observed %h expected %h", tag, k, $time, obs, exp);
    end
  endtask

  // Reference: strobe n of a run (n = 0,1,..) lands on cycle COL_DIV*(n+1)+1
  // after acceptance and shows column n%8 of character (n/8) mod message length.
  task automatic modelStep(int k, bit r, bit v, logic [5:0] ch, bit st, bit sp, bit cl);
    int dv;
    int n;
    dv = divOf(k);
    if (r) begin
      running[k] = 0; cnt[k] = 0; col_m[k] = 8'h00;
      strobe_m[k] = 0; first_m[k] = 0;
    end else if (!running[k]) begin
      strobe_m[k] = 0; first_m[k] = 0;
      if (cl) cnt[k] = 0;
      else begin
        if (v && cnt[k] < ML) begin
          mem[k][cnt[k]] = ch;
          cnt[k]++;
        end
        if (st && cnt[k] > 0) begin
          running[k] = 1;
          cyc[k] = 1;
        end
      end
    end else if (sp) begin
      running[k] = 0; strobe_m[k] = 0; first_m[k] = 0;
    end else begin
      cyc[k]++;
      if ((cyc[k] - 1) % dv == 0) begin
        n = (cyc[k] - 1) / dv - 1;
        strobe_m[k] = 1;
        col_m[k]    = glyph(mem[k][(n / 8) % cnt[k]], 3'(n % 8));
        first_m[k]  = (n % (8 * cnt[k]) == 0);
      end else begin
        strobe_m[k] = 0; first_m[k] = 0;
      end
    end
  endtask

  task automatic checkInstance(int k, bit r);
    int kn;
    logic [5:0] ef;
    logic [2:0] ei;
    ef = 6'd0; ei = 3'd0;
    if (running[k]) begin
      kn = (cyc[k] - 1) / divOf(k);
      ef = mem[k][(kn / 8) % cnt[k]];
      ei = 3'(kn % 8);
    end
    checkOutput("busy",       k, 8'(dut_busy[k]),   8'(running[k]));
    checkOutput("col_strobe", k, 8'(dut_strobe[k]), 8'(strobe_m[k]));
    checkOutput("col_first",  k, 8'(dut_first[k]),  8'(first_m[k]));
    checkOutput("col_out",    k, dut_col[k],        col_m[k]);
    checkOutput("char_ready", k, 8'(dut_ready[k]),  8'(!running[k] && cnt[k] < ML && !r));
    checkOutput("rom_face",   k, 8'(dut_face[k]),   8'(ef));
    checkOutput("rom_index",  k, 8'(dut_index[k]),  8'(ei));
  endtask

  task automatic applyStimulus(bit r, bit v, logic [5:0] ch, bit st, bit sp, bit cl);
    reset = r; char_valid = v; char_in = ch; start = st; stop = sp; clr = cl;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) modelStep(k, r, v, ch, st, sp, cl);
    for (int k = 0; k < 2; k++) checkInstance(k, r);
  endtask

  task automatic idleCycles(int n);
    for (int j = 0; j < n; j++) applyStimulus(0, 0, 6'($urandom), 0, 0, 0);
  endtask

  initial begin
    bit hit;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; running[k] = 0; cyc[k] = 0; col_m[k] = 8'h00;
      strobe_m[k] = 0; first_m[k] = 0;
    end
    reset = 1'b1; char_valid = 1'b0; char_in = 6'd0; start = 1'b0; stop = 1'b0; clr = 1'b0;

    $display("[TB] reset and empty-buffer start");
    applyStimulus(1, 1, 6'd3, 1, 0, 0);
    applyStimulus(1, 0, 6'd0, 0, 0, 0);
    idleCycles(2);
    applyStimulus(0, 0, 6'd0, 1, 0, 0);
    applyStimulus(0, 0, 6'd0, 1, 0, 0);
    idleCycles(3);

    $display("[TB] two-character message 'A','B'");
    applyStimulus(0, 1, 6'd1, 0, 0, 0);
    applyStimulus(0, 1, 6'd2, 0, 0, 0);
    applyStimulus(0, 0, 6'd0, 1, 0, 0);
    for (int j = 0; j < 80; j++)
      applyStimulus(0, 1'($urandom), 6'($urandom), 0, 0, 1'($urandom));

    $display("[TB] stop mid-column, then restart with stop held");
    hit = 0;
    for (int j = 0; j < 8 && !hit; j++) begin
      if ((cyc[0] - 1) % 4 == 2) hit = 1;
      else idleCycles(1);
    end
    checkOutput("stop_window", 0, 8'(hit), 8'd1);
    applyStimulus(0, 0, 6'd0, 0, 1, 0);
    idleCycles(6);
    applyStimulus(0, 0, 6'd0, 1, 1, 0);
    idleCycles(40);
    applyStimulus(0, 0, 6'd0, 0, 1, 0);

    $display("[TB] clear handling and start with simultaneous write");
    applyStimulus(0, 1, 6'd9, 0, 0, 1);
    applyStimulus(0, 0, 6'd0, 1, 0, 1);
    idleCycles(2);
    applyStimulus(0, 1, 6'd5, 1, 0, 0);
    idleCycles(40);
    applyStimulus(0, 0, 6'd0, 0, 1, 0);

    $display("[TB] full buffer, long scroll, reset mid-run");
    applyStimulus(0, 0, 6'd0, 0, 0, 1);
    for (int j = 0; j < 9; j++) applyStimulus(0, 1, 6'($urandom), 0, 0, 0);
    applyStimulus(0, 1, 6'($urandom), 1, 0, 0);
    for (int j = 0; j < 270; j++) applyStimulus(0, 1, 6'($urandom), 0, 0, 0);
    applyStimulus(1, 0, 6'd0, 0, 0, 0);
    idleCycles(2);

    $display("[TB] randomized traffic");
    for (int j = 0; j < 800; j++)
      applyStimulus(($urandom % 64) == 0, 1'($urandom), 6'($urandom),
                    ($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 16) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_scroller.md
CHAR_SCROLLER -- requirements
Module: char_scroller

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 8: message buffer depth in characters; power of two, 2..32.
REQ-002 The block SHALL have parameter COL_DIV, default 4: clock cycles per emitted column; 1..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 char_in  input  6  character code to append to the message buffer.
REQ-006 char_valid  input  1  char_in offered this cycle.
REQ-007 char_ready  output  1  buffer accepts a write this cycle.
REQ-008 start  input  1  level/pulse request to begin scrolling.
REQ-009 stop  input  1  request to end scrolling.
REQ-010 clr  input  1  empty the message buffer.
REQ-011 rom_face  output  6  character code presented to the glyph ROM.
REQ-012 rom_index  output  3  glyph column 0..7 presented to the glyph ROM.
REQ-013 rom_col  input  8  glyph column returned combinationally by the ROM for the current rom_face/rom_index.
REQ-014 col_out  output  8  last emitted column bitmap; bit 0 = top row.
REQ-015 col_strobe  output  1  one-cycle pulse: col_out is new.
REQ-016 col_first  output  1  high with col_strobe when the column is char 0, index 0.
REQ-017 busy  output  1  high while in RUN.

Function
REQ-018 The block SHALL have two states: IDLE (load) and RUN (scroll).
REQ-019 char_ready SHALL be (state==IDLE && count<MSG_LEN && !reset); a write occurs when char_valid && char_ready, storing char_in at buf[count], count+1.
REQ-020 In IDLE, clr SHALL set count=0 next cycle; clr with a simultaneous write: clr wins, write discarded; clr in RUN ignored.
REQ-021 In IDLE, start SHALL enter RUN next cycle if post-write count>0 (a write in the start cycle is included); start with count==0 and no write (or with clr) ignored.
REQ-022 On RUN entry: char pointer p=0, index i=0, divider d=0, rom_face=buf[0], rom_index=0 (rom_face/rom_index registered).
REQ-023 In RUN, d SHALL count 0..COL_DIV-1 and wrap; when d==COL_DIV-1, rom_col SHALL be captured into col_out and col_strobe=1 on the following cycle; col_first=1 on that cycle iff p==0 && i==0.
REQ-024 With start accepted at cycle T, the first col_strobe SHALL occur at T+COL_DIV+1, then every COL_DIV cycles.
REQ-025 After each capture, i SHALL increment; i==7 wraps to 0 and p increments; p==count-1 wraps to 0 (endless loop over the message); rom_face/rom_index update in the same edge.
REQ-026 COL_DIV==1 SHALL give col_strobe continuously high in steady RUN.
REQ-027 stop in RUN SHALL return to IDLE next cycle: no capture that cycle, col_strobe=0, col_out holds, rom_face/rom_index=0, buffer and count preserved; start and stop together in IDLE: stop ignored.
REQ-028 Writes SHALL not occur in RUN (char_ready=0); buffer contents are static while scrolling.

Reset
REQ-029 While reset is high, next edge: state=IDLE, count=0, p=0, i=0, d=0, rom_face=0, rom_index=0, col_out=0, col_strobe=0, col_first=0, busy=0; buffer contents undefined.
REQ-030 Reset SHALL override all inputs, including mid-RUN; char_ready=0 while reset high.

Verification
REQ-031 Load 'A','B' (codes 1,2), start, COL_DIV=4 -> busy at T+1; strobes at T+5,T+9,...; 16 columns match ROM(1,0..7),ROM(2,0..7); 17th column = ROM(1,0) with col_first=1.
REQ-032 Write 8 chars with MSG_LEN=8 -> char_ready=0 after 8th; 9th char_valid not stored; count stays 8.
REQ-033 start with empty buffer -> stays IDLE, busy=0, no strobe; start with a simultaneous write of code 5 -> RUN, all columns from face 5.
REQ-034 stop during RUN at d==2 -> IDLE next cycle, no further strobe, col_out unchanged; restart -> scroll resumes at char 0, index 0.
REQ-035 reset asserted mid-RUN -> all outputs zero next cycle, count=0, char_ready=1 after reset released.
REQ-036 COL_DIV=1, one char -> col_strobe high every cycle from T+2, index sequence 0..7 repeating, col_first every 8th strobe.
